gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe: RTL and testbench

GF180MCU_FD_SC_MCU9T5V0__DFFNQ_PIPE -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__pipe_pkg.sv | 16 +
 rtl/gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe_stage.sv | 50 +++++
 rtl/gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe.sv | 97 +++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pipe_pkg.sv
// Shared limits and helpers for the negative-edge scan pipeline.
//   WIDTH_MIN/WIDTH_MAX : legal data bits per stage
//   DEPTH_MIN/DEPTH_MAX : legal number of stages
//   fill_width(depth)   : bits needed to count 0..depth valid stages
package gf180mcu_fd_sc_mcu9t5v0__pipe_pkg;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 64;
    localparam int unsigned DEPTH_MIN = 1;
    localparam int unsigned DEPTH_MAX = 32;

    function automatic int unsigned fill_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe_stage.sv
// One pipeline stage: WIDTH-bit data word plus valid flag, falling-edge clocked.
//   clkn : clock, state updates on falling edge
//   rst  : synchronous active-high clear (highest priority)
//   se   : scan shift; data shifts toward MSB, si enters bit 0, valid holds
//   en   : functional load of d/dv
//   d/dv : word and valid flag from the previous stage (or pipe input)
//   si   : scan serial input
//   q/qv : registered word and valid flag
module gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clkn,
    input  logic             rst,
    input  logic             se,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             dv,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             qv
);

    logic [WIDTH-1:0] data_d, data_q;
    logic             valid_d, valid_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (rst) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (se) begin
            // Shift-then-patch keeps WIDTH=1 legal (no [WIDTH-2:0] slice).
            data_d    = data_q << 1;
            data_d[0] = si;
        end else if (en) begin
            data_d  = d;
            valid_d = dv;
        end
    end

    always_ff @(negedge clkn) begin
        data_q  <= data_d;
        valid_q <= valid_d;
    end

    assign q  = data_q;
    assign qv = valid_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe.sv
// DEPTH-stage, WIDTH-bit falling-edge pipeline with valid flags, scan chain
// and an occupancy counter.
//   CLKN : clock, all state updates on falling edge
//   RST  : synchronous active-high reset (priority RST > SE > E > hold)
//   E    : functional shift enable
//   D/DV : data word and valid flag into stage 0
//   SE   : scan enable; SI -> s0[0..W-1] -> s1[0..] ... -> SO
//   SI   : scan serial input
//   Q/QV : word and valid flag of the last stage
//   SO   : MSB of the last stage
//   FILL : number of stages whose valid flag is set
module gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe
    import gf180mcu_fd_sc_mcu9t5v0__pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          CLKN,
    input  logic                          RST,
    input  logic                          E,
    input  logic [WIDTH-1:0]              D,
    input  logic                          DV,
    input  logic                          SE,
    input  logic                          SI,
    output logic [WIDTH-1:0]              Q,
    output logic                          QV,
    output logic                          SO,
    output logic [fill_width(DEPTH)-1:0]  FILL
);

    localparam int unsigned FW = fill_width(DEPTH);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("WIDTH out of range");
    end
    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("DEPTH out of range");
    end

    logic [WIDTH-1:0] data  [DEPTH];
    logic             valid [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_first
            gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .clkn (CLKN),
                .rst  (RST),
                .se   (SE),
                .en   (E),
                .d    (D),
                .dv   (DV),
                .si   (SI),
                .q    (data[k]),
                .qv   (valid[k])
            );
        end else begin : g_next
            gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .clkn (CLKN),
                .rst  (RST),
                .se   (SE),
                .en   (E),
                .d    (data[k-1]),
                .dv   (valid[k-1]),
                .si   (data[k-1][WIDTH-1]),
                .q    (data[k]),
                .qv   (valid[k])
            );
        end
    end

    // Occupancy tracked incrementally: a valid word entering adds one, a valid
    // word leaving the last stage subtracts one; both together cancel.
    logic [FW-1:0] fill_d, fill_q;

    always_comb begin
        fill_d = fill_q;
        if (RST) begin
            fill_d = '0;
        end else if (!SE && E) begin
            case ({DV, valid[DEPTH-1]})
                2'b10:   fill_d = fill_q + FW'(1);
                2'b01:   fill_d = fill_q - FW'(1);
                default: fill_d = fill_q;
            endcase
        end
    end

    always_ff @(negedge CLKN) begin
        fill_q <= fill_d;
    end

    assign Q    = data[DEPTH-1];
    assign QV   = valid[DEPTH-1];
    assign SO   = data[DEPTH-1][WIDTH-1];
    assign FILL = fill_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe.sv
module tb_gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe;

    logic       CLKN;
    logic       RST, E, DV, SE, SI;
    logic [7:0] D;
    logic [7:0] Q;
    logic       QV, SO;
    logic [2:0] FILL;

    int n_vec;
    int n_err;

    gf180mcu_fd_sc_mcu9t5v0__dffnq_pipe #(.WIDTH(8), .DEPTH(4)) dut (
        .CLKN (CLKN),
        .RST  (RST),
        .E    (E),
        .D    (D),
        .DV   (DV),
        .SE   (SE),
        .SI   (SI),
        .Q    (Q),
        .QV   (QV),
        .SO   (SO),
        .FILL (FILL)
    );

    initial begin
        CLKN = 1'b1;
        forever #5 CLKN = ~CLKN;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst, se, e;
        logic [7:0] d;
        logic       dv;
        logic [7:0] q;
        logic       qv;
        logic [2:0] fill;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic se, logic e, logic [7:0] d, logic dv,
                                logic [7:0] q, logic qv, logic [2:0] fill);
        vec_t v;
        v.rst = rst; v.se = se; v.e = e; v.d = d; v.dv = dv;
        v.q = q; v.qv = qv; v.fill = fill;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs between falling edges, then sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic se, input logic e,
                        input logic [7:0] d, input logic dv, input logic si);
        @(posedge CLKN);
        RST = rst; SE = se; E = e; D = d; DV = dv; SI = si;
        @(negedge CLKN);
        #1;
        n_vec++;
    endtask

    task automatic check_all(input string tag, input logic [7:0] q, input logic qv,
                             input logic [2:0] fill);
        check({tag, ".Q"},    32'(Q),    32'(q));
        check({tag, ".QV"},   32'(QV),   32'(qv));
        check({tag, ".FILL"}, 32'(FILL), 32'(fill));
        check({tag, ".SO"},   32'(SO),   32'(q[7]));
    endtask

    logic [31:0] chain;
    logic [31:0] word;

    initial begin
        n_vec = 0;
        n_err = 0;
        RST = 1'b0; E = 1'b0; SE = 1'b0; SI = 1'b0; D = '0; DV = 1'b0;

        //            rst se e  d      dv   q      qv  fill
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 3'd0));
        tbl.push_back(mk(0, 0, 1, 8'h11, 1, 8'h00, 0, 3'd1));
        tbl.push_back(mk(0, 0, 1, 8'h22, 1, 8'h00, 0, 3'd2));
        tbl.push_back(mk(0, 0, 0, 8'hFF, 1, 8'h00, 0, 3'd2));
        tbl.push_back(mk(0, 0, 0, 8'hFF, 1, 8'h00, 0, 3'd2));
        tbl.push_back(mk(0, 0, 0, 8'hFF, 1, 8'h00, 0, 3'd2));
        tbl.push_back(mk(0, 0, 1, 8'h33, 1, 8'h00, 0, 3'd3));
        tbl.push_back(mk(0, 0, 1, 8'h44, 1, 8'h11, 1, 3'd4));
        tbl.push_back(mk(0, 0, 1, 8'h55, 1, 8'h22, 1, 3'd4));
        tbl.push_back(mk(0, 0, 1, 8'h66, 1, 8'h33, 1, 3'd4));
        tbl.push_back(mk(0, 0, 1, 8'h77, 0, 8'h44, 1, 3'd3));
        tbl.push_back(mk(0, 0, 1, 8'h88, 0, 8'h55, 1, 3'd2));
        tbl.push_back(mk(0, 0, 1, 8'h99, 0, 8'h66, 1, 3'd1));
        tbl.push_back(mk(0, 0, 1, 8'hAA, 0, 8'h77, 0, 3'd0));
        tbl.push_back(mk(0, 0, 1, 8'hBB, 0, 8'h88, 0, 3'd0));
        tbl.push_back(mk(1, 0, 1, 8'hCC, 1, 8'h00, 0, 3'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].se, tbl[i].e, tbl[i].d, tbl[i].dv, 1'b0);
            check_all($sformatf("vec%0d", i), tbl[i].q, tbl[i].qv, tbl[i].fill);
        end

        // Scan: two valid words loaded, then 32 bits shifted through the chain.
        step(0, 0, 1, 8'h0F, 1, 1'b0);
        step(0, 0, 1, 8'hF0, 1, 1'b0);
        check_all("scan_pre", 8'h00, 1'b0, 3'd2);
        chain = 32'h0000_0FF0;  // {s3,s2,s1,s0}
        word  = 32'hA5A5_A5A5;
        for (int unsigned b = 0; b < 32; b++) begin
            step(0, 1, 1, 8'hFF, 1, word[b]);
            chain = {chain[30:0], word[b]};
            check($sformatf("scan%0d.SO", b), 32'(SO), 32'(chain[31]));
            check($sformatf("scan%0d.QV", b), 32'(QV), 32'(1'b0));
            check($sformatf("scan%0d.FILL", b), 32'(FILL), 32'(3'd2));
        end
        check("scan_end.Q", 32'(Q), 32'(8'hA5));

        // Reset after scan preload, then scan out: every chain bit must be zero.
        step(1, 0, 0, 8'h00, 0, 1'b0);
        check_all("rst_after_scan", 8'h00, 1'b0, 3'd0);
        for (int unsigned b = 0; b < 32; b++) begin
            step(0, 1, 0, 8'h00, 0, 1'b0);
            check($sformatf("rst_scanout%0d.SO", b), 32'(SO), 32'(1'b0));
        end

        // Priority: fill with 0xFF, then RST+SE+E together must zero, not shift.
        for (int unsigned i = 0; i < 4; i++) step(0, 0, 1, 8'hFF, 1, 1'b0);
        check_all("prio_full", 8'hFF, 1'b1, 3'd4);
        step(1, 1, 1, 8'hFF, 1, 1'b1);
        check_all("prio_rst", 8'h00, 1'b0, 3'd0);
        for (int unsigned b = 0; b < 32; b++) begin
            step(0, 1, 0, 8'h00, 0, 1'b0);
            check($sformatf("prio_scanout%0d.SO", b), 32'(SO), 32'(1'b0));
        end

        // RST pulse between falling edges must not disturb state.
        for (int unsigned i = 0; i < 4; i++) step(0, 0, 1, 8'h5A, 1, 1'b0);
        check_all("glitch_pre", 8'h5A, 1'b1, 3'd4);
        #2 RST = 1'b1;
        #2 RST = 1'b0;
        step(0, 0, 0, 8'h00, 0, 1'b0);
        check_all("glitch_post", 8'h5A, 1'b1, 3'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
